// File: rtl/ff_arb_pkg.sv
// Shared definitions for the flip-flop bank load arbiter.
package ff_arb_pkg;

  // Upper bound on the number of requesters the picker is built for.
  localparam int unsigned MAX_NREQ = 8;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ff_load_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
module rr_pick
  import ff_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    any_req
);

  localparam int unsigned PW = $clog2(NREQ);

  logic          w_found;
  logic [PW-1:0] w_idx;

  // Scan upward from ptr; the loop is sized for MAX_NREQ and masked to NREQ.
  always_comb begin
    winner  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      if (i < NREQ) begin
        w_idx = PW'((32'(ptr) + i) % NREQ);
        if (!w_found && req[w_idx]) begin
          w_found = 1'b1;
          winner  = w_idx;
        end
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/ff_load_arbiter.sv
// Round-robin controller that shares one clock-enabled, sync-reset register
// bank among NREQ requesters, with a guard gap after each load.
module ff_load_arbiter
  import ff_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                    Clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  input  logic                    clr_req,
  output logic [NREQ-1:0]         ack,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [WIDTH-1:0]        reg_D,
  output logic                    reg_ce,
  output logic                    reg_reset,
  output logic                    busy
);

  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] GAP_START = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_t      r_state;
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_gap;
  logic [NREQ-1:0] r_ack;
  logic [PW-1:0]   r_grant;
  logic [WIDTH-1:0] r_D;
  logic            r_ce;
  logic            r_rst;
  logic            r_busy;

  logic [PW-1:0]   w_winner;
  logic            w_any;
  logic [PW-1:0]   w_ptr_next;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .ptr     (r_ptr),
    .winner  (w_winner),
    .any_req (w_any)
  );

  assign w_ptr_next = (r_grant == PW'(NREQ - 1)) ? '0 : r_grant + PW'(1);

  // Controller FSM; every output is a register set on entry to the state it belongs to.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gap   <= '0;
      r_ack   <= '0;
      r_grant <= '0;
      r_D     <= '0;
      r_ce    <= 1'b0;
      r_rst   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= '0;
      r_ce  <= 1'b0;
      r_rst <= 1'b0;
      case (r_state)
        IDLE: begin
          if (clr_req) begin
            r_state <= CLEAR;
            r_rst   <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_any) begin
            r_state <= LOAD;
            r_grant <= w_winner;
            r_D     <= data[32'(w_winner)*WIDTH +: WIDTH];
            r_ce    <= 1'b1;
            r_ack   <= {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          r_ptr <= w_ptr_next;
          if (GAP_CYCLES == 0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= GAP;
            r_gap   <= GAP_START;
          end
        end
        CLEAR: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        GAP: begin
          if (r_gap == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap <= r_gap - CW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign grant_id  = r_grant;
  assign reg_D     = r_D;
  assign reg_ce    = r_ce;
  assign reg_reset = r_rst;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ff_load_arbiter.sv
// Bench for ff_load_arbiter with an attached sync-reset, clock-enabled bank.
module tb_ff_load_arbiter;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic        clr_req = 1'b0;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic [7:0]  reg_D;
  logic        reg_ce;
  logic        reg_reset;
  logic        busy;

  logic [7:0]  q_bank = '0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic       clr;
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];

  logic       q_pend = 1'b0;
  logic [7:0] q_exp = '0;

  ff_load_arbiter #(.NREQ(4), .WIDTH(8), .GAP_CYCLES(2)) dut (
    .Clk       (Clk),
    .reset_n   (reset_n),
    .req       (req),
    .data      (data),
    .clr_req   (clr_req),
    .ack       (ack),
    .grant_id  (grant_id),
    .reg_D     (reg_D),
    .reg_ce    (reg_ce),
    .reg_reset (reg_reset),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // External register bank.
  always @(posedge Clk) begin
    if (reg_reset) q_bank <= '0;
    else if (reg_ce) q_bank <= reg_D;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per bank access and checks the bank one edge later.
  always @(negedge Clk) begin
    exp_t e;
    if (reset_n) begin
      if (q_pend) begin
        chk("bank_q", {24'b0, q_bank}, {24'b0, q_exp});
        q_pend = 1'b0;
      end
      if (reg_ce || reg_reset) begin
        chk("ce_reset_exclusive", {31'b0, reg_ce & reg_reset}, 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_access: ce=%0b reset=%0b ack=%b, expected no access", reg_ce, reg_reset, ack);
        end else begin
          e = sb.pop_front();
          if (e.clr) begin
            chk("clear_reset", {31'b0, reg_reset}, 32'd1);
            chk("clear_ack", {28'b0, ack}, 32'd0);
            q_exp = '0;
          end else begin
            chk("load_ce", {31'b0, reg_ce}, 32'd1);
            chk("load_ack", {28'b0, ack}, {28'b0, 4'b0001 << e.id});
            chk("load_grant_id", {30'b0, grant_id}, {30'b0, e.id});
            chk("load_reg_D", {24'b0, reg_D}, {24'b0, e.d});
            q_exp = e.d;
          end
          q_pend = 1'b1;
        end
      end
    end
  end

  task automatic set_lane(input int i, input logic [7:0] v);
    data[i*8 +: 8] = v;
  endtask

  task automatic wait_ack(output logic [3:0] a, output int c);
    a = '0;
    c = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk); #1;
      if (ack != 4'b0) begin
        a = ack;
        c = cyc;
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL ack_timeout: got no ack, expected one within 30 cycles");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30; i++) begin
      @(posedge Clk); #1;
      if (!busy) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL idle_timeout: busy still 1 after 30 cycles, expected 0");
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0] a;
    int c;
    int prev_c;
    logic [3:0] busy_exp;

    // Reset state.
    #2;
    chk("rst_ack", {28'b0, ack}, 32'd0);
    chk("rst_grant_id", {30'b0, grant_id}, 32'd0);
    chk("rst_reg_D", {24'b0, reg_D}, 32'd0);
    chk("rst_reg_ce", {31'b0, reg_ce}, 32'd0);
    chk("rst_reg_reset", {31'b0, reg_reset}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    reset_n = 1'b1;

    // 1: single load, busy for LOAD + 2 GAP cycles.
    set_lane(0, 8'hA5);
    req = 4'b0001;
    sb.push_back('{clr: 1'b0, id: 2'd0, d: 8'hA5});
    wait_ack(a, c);
    req = 4'b0000;
    busy_exp = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        @(posedge Clk); #1;
      end
      chk("t1_busy", {31'b0, busy}, {31'b0, busy_exp[i]});
    end

    // 2: round robin from ptr 0, next grant every GAP_CYCLES+2 edges.
    do_reset();
    set_lane(0, 8'h10); set_lane(1, 8'h21); set_lane(2, 8'h32); set_lane(3, 8'h43);
    for (int i = 0; i < 4; i++) sb.push_back('{clr: 1'b0, id: 2'(i), d: data[i*8 +: 8]});
    req = 4'b1111;
    prev_c = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(a, c);
      req = req & ~a;
      if (i > 0) chk("t2_spacing", 32'(c - prev_c), 32'd4);
      prev_c = c;
    end

    // 3: clear wins over a simultaneous request; the request is served afterwards.
    wait_idle();
    set_lane(2, 8'h5C);
    sb.push_back('{clr: 1'b1, id: 2'd0, d: 8'h00});
    sb.push_back('{clr: 1'b0, id: 2'd2, d: 8'h5C});
    clr_req = 1'b1;
    req = 4'b0100;
    @(posedge Clk); #1;
    chk("t3_reset_pulse", {31'b0, reg_reset}, 32'd1);
    clr_req = 1'b0;
    wait_ack(a, c);
    req = req & ~a;

    // 4: wrap from ptr 3, then ptr back at 1.
    wait_idle();
    set_lane(3, 8'hE7); set_lane(0, 8'h18);
    sb.push_back('{clr: 1'b0, id: 2'd3, d: 8'hE7});
    sb.push_back('{clr: 1'b0, id: 2'd0, d: 8'h18});
    req = 4'b1001;
    wait_ack(a, c);
    req = req & ~a;
    wait_ack(a, c);
    req = req & ~a;
    wait_idle();
    set_lane(1, 8'h6B);
    sb.push_back('{clr: 1'b0, id: 2'd1, d: 8'h6B});
    req = 4'b0011;
    wait_ack(a, c);
    req = 4'b0000;

    // 6: one-cycle request during GAP is not served and leaves ptr at 2.
    @(posedge Clk); #1;
    req = 4'b0001;
    @(posedge Clk); #1;
    req = 4'b0000;
    wait_idle();
    repeat (2) @(posedge Clk);
    #1;
    set_lane(2, 8'hC3);
    sb.push_back('{clr: 1'b0, id: 2'd2, d: 8'hC3});
    req = 4'b1101;
    wait_ack(a, c);
    req = 4'b0000;

    // 5: async reset during LOAD; afterwards ptr restarts at 0.
    wait_idle();
    set_lane(2, 8'h9D); set_lane(3, 8'h77);
    req = 4'b1100;
    wait_ack(a, c);
    chk("t5_pre_ack", {28'b0, a}, 32'b1000);
    reset_n = 1'b0;
    #1;
    chk("t5_ack", {28'b0, ack}, 32'd0);
    chk("t5_reg_ce", {31'b0, reg_ce}, 32'd0);
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_grant_id", {30'b0, grant_id}, 32'd0);
    chk("t5_reg_D", {24'b0, reg_D}, 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    sb.push_back('{clr: 1'b0, id: 2'd2, d: 8'h9D});
    reset_n = 1'b1;
    wait_ack(a, c);
    req = req & ~a;
    req = 4'b0000;

    wait_idle();
    repeat (3) @(posedge Clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
